op_hcompute_mult_stencil_stage: RTL and testbench

Compute stage of the pointwise app, sitting between `hw_input_global_wrapper_stencil_ub` (upstream) and `mult_stencil_ub` (downstream). It walks the statically scheduled 64×64 iteration domain and issues `ren` plus `ctrl_vars` to the upstream buffer. It multiplies each returned pixel by a constant through a fixed-latency pipeline, then issues `wen`, `ctrl_vars` and data to the downstream buffer. Both buffers are combinational-read / registered-write, so all scheduling lives in this block.

---
 rtl/pointwise_stage_pkg.sv | 17 +
 rtl/op_hcompute_mult_stencil_stage_affine_domain_counter.sv | 53 +++++
 rtl/op_hcompute_mult_stencil_stage.sv | 135 +++++++++++++
 tb/tb_op_hcompute_mult_stencil_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pointwise_stage_pkg.sv
// Shared types for the pointwise app compute stage.
// Iteration vars are packed [var][bit]; index 0 is the unused outer var.
package pointwise_stage_pkg;

    localparam int DATA_W        = 16;
    localparam int NUM_CTRL_VARS = 3;

    typedef logic [NUM_CTRL_VARS-1:0][DATA_W-1:0] ctrl_vars_t;

    typedef enum logic [1:0] {
        S_WAIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/op_hcompute_mult_stencil_stage_affine_domain_counter.sv
// Nested wrap counters walking the 2-D iteration domain.
// ctrl_vars_o[1] is the inner loop, ctrl_vars_o[2] the outer loop.
module affine_domain_counter
    import pointwise_stage_pkg::*;
#(
    parameter int W     = pointwise_stage_pkg::DATA_W,
    parameter int EXT_0 = 64,
    parameter int EXT_1 = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en_i,
    input  logic                              clr_i,
    output logic [NUM_CTRL_VARS-1:0][W-1:0]   ctrl_vars_o,
    output logic                              last_o
);

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         x_wrap;
    logic         y_wrap;

    assign x_wrap = (x_q == W'(EXT_0 - 1));
    assign y_wrap = (y_q == W'(EXT_1 - 1));
    assign last_o = x_wrap & y_wrap;

    assign ctrl_vars_o = {y_q, x_q, {W{1'b0}}};

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/op_hcompute_mult_stencil_stage.sv
// Pointwise multiply stage: schedules upstream reads, scales each pixel
// by a constant through a fixed-latency pipe, and writes downstream.
module op_hcompute_mult_stencil_stage
    import pointwise_stage_pkg::*;
#(
    parameter int DATA_W      = pointwise_stage_pkg::DATA_W,
    parameter int EXT_0       = 64,
    parameter int EXT_1       = 64,
    parameter int START_DELAY = 0,
    parameter int MUL_CONST   = 2,
    parameter int LAT         = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    output logic                                  rd_ren,
    output logic [NUM_CTRL_VARS-1:0][DATA_W-1:0]  rd_ctrl_vars,
    input  logic [DATA_W-1:0]                     rd_data,
    output logic                                  wr_wen,
    output logic [NUM_CTRL_VARS-1:0][DATA_W-1:0]  wr_ctrl_vars,
    output logic [DATA_W-1:0]                     wr_data,
    output logic                                  done
);

    localparam int DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

    typedef logic [NUM_CTRL_VARS-1:0][DATA_W-1:0] cv_t;

    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          dom_last;
    logic [DATA_W-1:0] prod;

    logic [LAT-1:0]    vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [LAT];
    cv_t               cv_q  [LAT];

    assign rd_ren = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign prod   = rd_data * DATA_W'(MUL_CONST);

    affine_domain_counter #(
        .W     (DATA_W),
        .EXT_0 (EXT_0),
        .EXT_1 (EXT_1)
    ) u_dom (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (rd_ren),
        .clr_i       (flush),
        .ctrl_vars_o (rd_ctrl_vars),
        .last_o      (dom_last)
    );

    // DRAIN looks at next-cycle valids so done lands one cycle after last wen
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        unique case (state_q)
            S_WAIT: begin
                if (dly_q == DW'(START_DELAY)) begin
                    state_d = S_RUN;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_RUN: begin
                if (dom_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (~|vld_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
        if (flush) begin
            state_d = S_WAIT;
            dly_d   = '0;
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_ren & ~flush;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            dly_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            vld_q   <= vld_d;
        end
    end

    // Payload only moves with a valid entry, so outputs hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
                cv_q[i]  <= '0;
            end
        end else begin
            if (rd_ren) begin
                dat_q[0] <= prod;
                cv_q[0]  <= rd_ctrl_vars;
            end
            for (int i = 1; i < LAT; i++) begin
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    cv_q[i]  <= cv_q[i-1];
                end
            end
        end
    end

    assign wr_wen       = vld_q[LAT-1];
    assign wr_data      = dat_q[LAT-1];
    assign wr_ctrl_vars = cv_q[LAT-1];

endmodule

// File: tb/tb_op_hcompute_mult_stencil_stage.sv
// Bench for the pointwise multiply stage: two configurations run side by
// side against a timeline model plus literal anchor checks.
module tb_op_hcompute_mult_stencil_stage;
    import pointwise_stage_pkg::*;

    localparam int N = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;

    logic ren_a, wen_a, done_a;
    logic ren_b, wen_b, done_b;
    ctrl_vars_t rv_a, wv_a, rv_b, wv_b;
    logic [15:0] rd_a, wd_a, rd_b, wd_b;

    logic [15:0] mem [N];

    assign rd_a = mem[{rv_a[2][5:0], rv_a[1][5:0]}];
    assign rd_b = mem[{rv_b[2][5:0], rv_b[1][5:0]}];

    op_hcompute_mult_stencil_stage u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .rd_ren(ren_a), .rd_ctrl_vars(rv_a), .rd_data(rd_a),
        .wr_wen(wen_a), .wr_ctrl_vars(wv_a), .wr_data(wd_a),
        .done(done_a)
    );

    op_hcompute_mult_stencil_stage #(
        .START_DELAY(5), .LAT(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .rd_ren(ren_b), .rd_ctrl_vars(rv_b), .rd_data(rd_b),
        .wr_wen(wen_b), .wr_ctrl_vars(wv_b), .wr_data(wd_b),
        .done(done_b)
    );

    // Cycle index since reset release / flush: -1 before the first edge
    int ta = -1;
    int tb = -1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ta <= -1;
        else if (flush_a) ta <= -1;
        else ta <= ta + 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb <= -1;
        else if (flush_b) tb <= -1;
        else tb <= tb + 1;
    end

    int checks = 0;
    int failures = 0;

    int a_rens, a_fren, a_fwen, a_done, a_lren;
    int b_fren, b_fwen, b_done;
    ctrl_vars_t a_frv, a_v64;
    logic [15:0] wlog [N];

    task automatic cmp(string nm, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (ta=%0d tb=%0d)",
                     nm, act, exp, ta, tb);
        end
    endtask

    function automatic ctrl_vars_t vars_of(int k);
        ctrl_vars_t v;
        v[0] = 16'd0;
        v[1] = 16'(k % 64);
        v[2] = 16'(k / 64);
        return v;
    endfunction

    task automatic chk_inst(string nm, int t, int sd, int lat,
                            logic ren, ctrl_vars_t rv, logic wen,
                            ctrl_vars_t wv, logic [15:0] wd, logic dn);
        logic er, ew, ed;
        int k;
        er = rst_n && t >= sd && t < sd + N;
        ew = rst_n && t >= sd + lat && t < sd + lat + N;
        ed = rst_n && t >= sd + lat + N;
        cmp({nm, ".ren"}, 48'(ren), 48'(er));
        cmp({nm, ".wen"}, 48'(wen), 48'(ew));
        cmp({nm, ".done"}, 48'(dn), 48'(ed));
        if (!rst_n) begin
            cmp({nm, ".rst_rvars"}, rv, 48'd0);
            cmp({nm, ".rst_wvars"}, wv, 48'd0);
            cmp({nm, ".rst_wdata"}, 48'(wd), 48'd0);
        end
        if (er) begin
            k = t - sd;
            cmp({nm, ".rvars"}, rv, vars_of(k));
        end
        if (ew && wen) begin
            k = t - sd - lat;
            cmp({nm, ".wvars"}, wv, vars_of(k));
            cmp({nm, ".wdata"}, 48'(wd),
                48'((32'(mem[k]) * 2) % 65536));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk_inst("A", ta, 0, 2, ren_a, rv_a, wen_a, wv_a, wd_a, done_a);
        chk_inst("B", tb, 5, 1, ren_b, rv_b, wen_b, wv_b, wd_b, done_b);
        if (ta < 0) begin
            a_rens = 0; a_fren = -99; a_fwen = -99;
            a_done = -99; a_lren = -99;
        end else begin
            if (ren_a) begin
                if (a_rens == 0) begin
                    a_fren = ta;
                    a_frv  = rv_a;
                end
                if (ta == 64) a_v64 = rv_a;
                a_rens++;
                a_lren = ta;
            end
            if (wen_a) begin
                if (a_fwen < 0) a_fwen = ta;
                wlog[{wv_a[2][5:0], wv_a[1][5:0]}] = wd_a;
            end
            if (done_a && a_done < 0) a_done = ta;
        end
        if (tb < 0) begin
            b_fren = -99; b_fwen = -99; b_done = -99;
        end else begin
            if (ren_b && b_fren < 0) b_fren = tb;
            if (wen_b && b_fwen < 0) b_fwen = tb;
            if (done_b && b_done < 0) b_done = tb;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 6000; i++) begin
            if (done_a && done_b) break;
            tick();
        end
        cmp("done_within_budget", 48'(done_a && done_b), 48'd1);
        tick();
    endtask

    task automatic wait_ta(int target);
        for (int i = 0; i < 6000; i++) begin
            if (ta == target) break;
            tick();
        end
        cmp("reach_iteration", 48'(ta), 48'(target));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic reset_cycles();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 16'(i);
        repeat (3) tick();

        // Run 1: plain schedule, data = address
        release_reset();
        wait_done();
        cmp("a_first_ren_cycle", 48'(a_fren), 48'd0);
        cmp("a_first_ren_vars", a_frv, 48'd0);
        cmp("a_ren_count", 48'(a_rens), 48'd4096);
        cmp("a_last_ren_cycle", 48'(a_lren), 48'd4095);
        cmp("a_wrap_vars", a_v64, {16'd1, 16'd0, 16'd0});
        cmp("a_first_wen_cycle", 48'(a_fwen), 48'd2);
        cmp("a_done_cycle", 48'(a_done), 48'd4098);
        cmp("a_wdata_100", 48'(wlog[100]), 48'd200);
        cmp("a_wdata_4095", 48'(wlog[4095]), 48'h1ffe);
        cmp("b_first_ren_cycle", 48'(b_fren), 48'd5);
        cmp("b_first_wen_cycle", 48'(b_fwen), 48'd6);
        cmp("b_done_cycle", 48'(b_done), 48'd4102);

        // Run 2: truncating products and a flush at iteration 100
        reset_cycles();
        mem[3] = 16'h9000;
        mem[4] = 16'h1234;
        release_reset();
        wait_ta(100);
        cmp("flush_cycle_wen", 48'(wen_a), 48'd1);
        cmp("flush_cycle_wvars", wv_a, {16'd1, 16'd34, 16'd0});
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        cmp("post_flush_wen", 48'(wen_a), 48'd0);
        cmp("post_flush_done", 48'(done_a), 48'd0);
        wait_done();
        cmp("rerun_ren_count", 48'(a_rens), 48'd4096);
        cmp("rerun_first_ren", 48'(a_fren), 48'd0);
        cmp("rerun_done_cycle", 48'(a_done), 48'd4098);
        cmp("trunc_9000", 48'(wlog[3]), 48'h2000);
        cmp("trunc_1234", 48'(wlog[4]), 48'h2468);

        // Run 3: asynchronous reset in the middle of RUN
        reset_cycles();
        mem[3] = 16'd3;
        mem[4] = 16'd4;
        release_reset();
        wait_ta(1000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        cmp("async_rst_ren", 48'(ren_a), 48'd0);
        cmp("async_rst_wen", 48'(wen_a), 48'd0);
        cmp("async_rst_rvars", rv_a, 48'd0);
        cmp("async_rst_wdata", 48'(wd_a), 48'd0);
        cmp("async_rst_b_ren", 48'(ren_b), 48'd0);
        repeat (3) tick();
        release_reset();
        wait_done();
        cmp("replay_ren_count", 48'(a_rens), 48'd4096);
        cmp("replay_done_cycle", 48'(a_done), 48'd4098);
        cmp("replay_wdata_1000", 48'(wlog[1000]), 48'd2000);
        cmp("replay_wdata_3", 48'(wlog[3]), 48'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
